// File: rtl/hci_bank_arbiter_ts_pkg.sv
// Shared types and constants for the TCDM bank arbiter with test-and-set sequencing.
package hci_bank_arbiter_ts_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    TS_WR = 1'b1
  } hci_bank_arb_state_t;

  localparam logic HCI_ARB_RR   = 1'b0;
  localparam logic HCI_ARB_PRIO = 1'b1;

endpackage

// File: rtl/hci_bank_arbiter_ts_if.sv
// Initiator-side and bank-side signal bundle of one bank arbiter instance.
interface hci_bank_arbiter_ts_if #(
  parameter int unsigned N   = 6,
  parameter int unsigned AW  = 32,
  parameter int unsigned AWM = 12,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = 8
);
  localparam int unsigned NB = DW / BW;

  logic [N-1:0]          req_i;
  logic [N-1:0][AW-1:0]  add_i;
  logic [N-1:0]          wen_i;
  logic [N-1:0][DW-1:0]  data_i;
  logic [N-1:0][NB-1:0]  be_i;
  logic [N-1:0]          gnt_o;
  logic [N-1:0]          r_valid_o;
  logic [DW-1:0]         r_data_o;

  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic [AWM-1:0]        mem_add_o;
  logic                  mem_wen_o;
  logic [DW-1:0]         mem_data_o;
  logic [NB-1:0]         mem_be_o;
  logic [DW-1:0]         mem_r_data_i;

  modport slave (
    input  req_i, add_i, wen_i, data_i, be_i, mem_gnt_i, mem_r_data_i,
    output gnt_o, r_valid_o, r_data_o, mem_req_o, mem_add_o, mem_wen_o, mem_data_o, mem_be_o
  );

  modport master (
    output req_i, add_i, wen_i, data_i, be_i, mem_gnt_i, mem_r_data_i,
    input  gnt_o, r_valid_o, r_data_o, mem_req_o, mem_add_o, mem_wen_o, mem_data_o, mem_be_o
  );

endinterface

// File: rtl/hci_rr_arbiter.sv
// Pointer-based round-robin picker: first requester at or after the pointer wins;
// the pointer moves past the winner when advance_i reports a completed transfer.
module hci_rr_arbiter #(
  parameter  int unsigned NUM = 4,
  localparam int unsigned IW  = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [NUM-1:0] req_i,
  input  logic           advance_i,
  output logic [IW-1:0]  idx_o,
  output logic           valid_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM; off++) begin
      cand = IW'((32'(ptr_q) + off) % NUM);
      if (!valid_o && req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= IW'((32'(idx_o) + 1) % NUM);
    end
  end

endmodule

// File: rtl/hci_bank_arbiter_ts.sv
// Per-bank TCDM arbiter (round-robin or CH0-priority with CH1 anti-starvation) that
// turns test-and-set reads into an atomic read + all-ones write. Optional HCI_BANK_ARB_PERF_EN.
module hci_bank_arbiter_ts
  import hci_bank_arbiter_ts_pkg::*;
#(
  parameter int unsigned N_CH0     = 4,
  parameter int unsigned N_CH1     = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned AWM       = 12,
  parameter int unsigned DW        = 32,
  parameter int unsigned BW        = 8,
  parameter int unsigned TS_BIT    = 21,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       arb_policy_i,
`ifdef HCI_BANK_ARB_PERF_EN
  output logic [31:0]                perf_conflict_o,
  output logic [31:0]                perf_ts_o,
`endif
  hci_bank_arbiter_ts_if.slave       bus
);

  localparam int unsigned N  = N_CH0 + N_CH1;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned I1 = (N_CH1 > 1) ? $clog2(N_CH1) : 1;
  localparam int unsigned SW = $clog2(MAX_STALL + 1);

  hci_bank_arb_state_t state_q, state_d;
  logic                policy_q;
  logic [AWM-1:0]      ts_add_q;
  logic [N-1:0]        rvalid_q;
  logic [SW-1:0]       stall_q;

  logic [N-1:0]        req;
  logic [IW-1:0]       rr_idx, c0_idx, win_idx;
  logic                rr_valid, c0_valid, win_valid;
  logic [I1-1:0]       c1_idx;
  logic                c1_valid;
  logic [AW-1:0]       win_add;
  logic                win_rd, is_ts, xfer, ch1_pend, ch1_xfer;
  logic [N-1:0]        gnt;
  logic                unused_add_bits;

  assign req = bus.req_i;

  hci_rr_arbiter #(.NUM(N)) i_rr_all (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req),
    .advance_i (xfer && (policy_q == HCI_ARB_RR)),
    .idx_o     (rr_idx),
    .valid_o   (rr_valid)
  );

  hci_rr_arbiter #(.NUM(N_CH1)) i_rr_ch1 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req[N-1:N_CH0]),
    .advance_i (ch1_xfer && (policy_q == HCI_ARB_PRIO)),
    .idx_o     (c1_idx),
    .valid_o   (c1_valid)
  );

  always_comb begin
    c0_idx   = '0;
    c0_valid = 1'b0;
    for (int unsigned i = N_CH0; i > 0; i--) begin
      if (req[i-1]) begin
        c0_idx   = IW'(i - 1);
        c0_valid = 1'b1;
      end
    end
  end

  // Priority mode: CH1 wins when CH0 is idle or the stall counter has saturated.
  always_comb begin
    win_idx   = rr_idx;
    win_valid = rr_valid;
    if (policy_q == HCI_ARB_PRIO) begin
      if (c1_valid && (!c0_valid || (stall_q == SW'(MAX_STALL)))) begin
        win_idx   = IW'(N_CH0) + IW'(c1_idx);
        win_valid = 1'b1;
      end else begin
        win_idx   = c0_idx;
        win_valid = c0_valid;
      end
    end
  end

  assign win_add         = bus.add_i[win_idx];
  assign win_rd          = bus.wen_i[win_idx];
  assign is_ts           = win_rd && win_add[TS_BIT];
  assign xfer            = win_valid && bus.mem_gnt_i && (state_q == IDLE);
  assign ch1_pend        = |req[N-1:N_CH0];
  assign ch1_xfer        = xfer && (win_idx >= IW'(N_CH0));
  assign unused_add_bits = ^win_add;

  always_comb begin
    gnt = '0;
    if (xfer) gnt[win_idx] = 1'b1;
  end

  assign bus.gnt_o     = gnt;
  assign bus.r_valid_o = rvalid_q;
  assign bus.r_data_o  = (|rvalid_q) ? bus.mem_r_data_i : '0;

  always_comb begin
    bus.mem_req_o  = 1'b0;
    bus.mem_add_o  = '0;
    bus.mem_wen_o  = 1'b0;
    bus.mem_data_o = '0;
    bus.mem_be_o   = '0;
    if (state_q == TS_WR) begin
      bus.mem_req_o  = 1'b1;
      bus.mem_add_o  = ts_add_q;
      bus.mem_data_o = '1;
      bus.mem_be_o   = '1;
    end else if (win_valid) begin
      bus.mem_req_o  = 1'b1;
      bus.mem_add_o  = win_add[AWM+1:2];
      bus.mem_wen_o  = win_rd;
      bus.mem_data_o = bus.data_i[win_idx];
      bus.mem_be_o   = bus.be_i[win_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer && is_ts) state_d = TS_WR;
      TS_WR:   if (bus.mem_gnt_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      policy_q <= HCI_ARB_RR;
      ts_add_q <= '0;
      rvalid_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      policy_q <= arb_policy_i;
      if (xfer && is_ts) ts_add_q <= win_add[AWM+1:2];
      rvalid_q <= (xfer && win_rd) ? gnt : '0;
      if (!ch1_pend || ch1_xfer) begin
        stall_q <= '0;
      end else if (stall_q != SW'(MAX_STALL)) begin
        stall_q <= stall_q + SW'(1);
      end
    end
  end

`ifdef HCI_BANK_ARB_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_conflict_o <= '0;
      perf_ts_o       <= '0;
    end else begin
      if ($countones(req) >= 2) perf_conflict_o <= perf_conflict_o + 32'd1;
      if ((state_q == TS_WR) && bus.mem_gnt_i) perf_ts_o <= perf_ts_o + 32'd1;
    end
  end
`endif

endmodule
